// File: rtl/riscy_pkg.sv
// Shared definitions for the riscy 4-phase microcontroller core.
// No logic here: opcode/phase encodings, branch condition codes, field extraction.
// Fields live in the 16-bit control half of the instruction word, above IMM.
package riscy_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LDA  = 4'd6,
    OP_LDB  = 4'd7,
    OP_STA  = 4'd8,
    OP_OUT  = 4'd9,
    OP_DIR  = 4'd10,
    OP_IN   = 4'd11,
    OP_JMP  = 4'd12,
    OP_CALL = 4'd13,
    OP_RET  = 4'd14,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    PH_FETCH  = 2'd0,
    PH_DECODE = 2'd1,
    PH_EXEC   = 2'd2,
    PH_UPDATE = 2'd3
  } phase_e;

  // Branch condition select, SEL[1:0]; SEL[3] inverts the result
  localparam logic [1:0] CC_ALWAYS = 2'd0;
  localparam logic [1:0] CC_Z      = 2'd1;
  localparam logic [1:0] CC_C      = 2'd2;
  localparam logic [1:0] CC_S      = 2'd3;

  // Bit positions inside the 16-bit control half {OP, SEL, ADR}
  localparam int OP_LSB  = 12;
  localparam int SEL_LSB = 8;
  localparam int ADR_LSB = 0;

  function automatic logic [3:0] ctl_op(input logic [15:0] ctl);
    return ctl[OP_LSB +: 4];
  endfunction

  function automatic logic [3:0] ctl_sel(input logic [15:0] ctl);
    return ctl[SEL_LSB +: 4];
  endfunction

  function automatic logic [7:0] ctl_adr(input logic [15:0] ctl);
    return ctl[ADR_LSB +: 8];
  endfunction

endpackage

// File: rtl/riscy_alu_p.sv
// Combinational ALU for ADD/SUB/AND/OR/XOR with Z/S/C flag generation.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result is consumed by the core in its EXEC phase.
module riscy_alu_p #(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              z,
  output logic              s,
  output logic              c
);
  import riscy_pkg::*;

  logic [DATA_W:0] sum;

  // Result and flags; carry is ADD carry-out or SUB borrow, zero for logic ops
  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      OP_SUB: begin
        res = a - b;
        c   = (a < b);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
    z = (res == '0);
    s = res[DATA_W-1];
  end

endmodule

// File: rtl/riscy_core_p.sv
// Four-phase accumulator microcontroller: FETCH, DECODE, EXEC, UPDATE per instruction.
// Latency: every instruction takes exactly four cycles; RAM reads land in UPDATE.
// Backpressure: none; HALT or a stack fault freezes the core until RST.
module riscy_core_p #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 5,
  parameter int RAM_AW  = 5,
  parameter int NPORTS  = 2,
  parameter int STACK_D = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic [PC_W-1:0]            ROM_ADDR,
  input  logic [16+DATA_W-1:0]       ROM_DATA,
  output logic [RAM_AW-1:0]          RAM_ADDR,
  output logic [DATA_W-1:0]          RAM_WDATA,
  output logic                       RAM_WE,
  input  logic [DATA_W-1:0]          RAM_RDATA,
  input  logic [NPORTS*DATA_W-1:0]   PORT_IN,
  output logic [NPORTS*DATA_W-1:0]   PORT_OUT,
  output logic [NPORTS*DATA_W-1:0]   PORT_OE,
  output logic [1:0]                 PHASE,
  output logic                       HALTED,
  output logic                       ERR
);
  import riscy_pkg::*;

  localparam int IW   = 16 + DATA_W;
  localparam int SP_W = $clog2(STACK_D + 1);
  localparam int PW   = NPORTS * DATA_W;

  // Architectural state
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              z_q, z_d, s_q, s_d, c_q, c_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [PC_W-1:0]   stack_q [STACK_D];
  logic [PC_W-1:0]   stack_d [STACK_D];
  logic [PW-1:0]     port_out_q, port_out_d, port_oe_q, port_oe_d;
  phase_e            phase_q, phase_d;
  logic              halted_q, halted_d, err_q, err_d;

  // Decoded fields of the held instruction
  logic [15:0]       ctl;
  logic [3:0]        op_raw;
  op_e               op;
  logic [3:0]        sel;
  logic [7:0]        adr;
  logic [DATA_W-1:0] imm;
  logic              adr_unused;

  assign ctl    = ir_q[IW-1:DATA_W];
  assign op_raw = ctl_op(ctl);
  assign op     = op_e'(op_raw);
  assign sel    = ctl_sel(ctl);
  assign adr    = ctl_adr(ctl);
  assign imm    = ir_q[DATA_W-1:0];
  // ADR is truncated to PC_W / RAM_AW; the upper bits are intentionally ignored
  assign adr_unused = ^adr;

  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_s, alu_c;

  riscy_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op  (op_raw),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res),
    .z   (alu_z),
    .s   (alu_s),
    .c   (alu_c)
  );

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_tgt;
  logic [PC_W-1:0]   pop_pc;
  logic [DATA_W-1:0] in_slice;
  logic              cond_raw, jmp_taken;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = adr[PC_W-1:0];

  // Branch condition, stack top and selected input port slice
  always_comb begin
    case (sel[1:0])
      CC_Z:    cond_raw = z_q;
      CC_C:    cond_raw = c_q;
      CC_S:    cond_raw = s_q;
      default: cond_raw = 1'b1;
    endcase
    jmp_taken = cond_raw ^ sel[3];

    pop_pc = '0;
    for (int i = 0; i < STACK_D; i++) begin
      if (int'(sp_q) == i + 1) pop_pc = stack_q[i];
    end

    // Ports at or beyond NPORTS never match, so IN reads them as zero
    in_slice = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (int'(sel[2:0]) == p) in_slice = PORT_IN[p*DATA_W +: DATA_W];
    end
  end

  // Next-state logic for the phase sequencer and everything it updates
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ram_addr_d = ram_addr_q;
    a_d        = a_q;
    b_d        = b_q;
    z_d        = z_q;
    s_d        = s_q;
    c_d        = c_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    port_out_d = port_out_q;
    port_oe_d  = port_oe_q;
    phase_d    = phase_q;
    halted_d   = halted_q;
    err_d      = err_q;

    if (!halted_q) begin
      case (phase_q)
        PH_FETCH: begin
          ir_d    = ROM_DATA;
          phase_d = PH_DECODE;
        end
        PH_DECODE: begin
          ram_addr_d = adr[RAM_AW-1:0];
          phase_d    = PH_EXEC;
        end
        PH_EXEC: begin
          phase_d = PH_UPDATE;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              a_d = alu_res;
              z_d = alu_z;
              s_d = alu_s;
              c_d = alu_c;
            end
            OP_LDA: if (!sel[0]) a_d = imm;
            OP_LDB: if (!sel[0]) b_d = imm;
            OP_OUT: begin
              for (int p = 0; p < NPORTS; p++) begin
                if (int'(sel[2:0]) == p) port_out_d[p*DATA_W +: DATA_W] = a_q;
              end
            end
            OP_DIR: begin
              for (int p = 0; p < NPORTS; p++) begin
                if (int'(sel[2:0]) == p) port_oe_d[p*DATA_W +: DATA_W] = imm;
              end
            end
            OP_IN:   a_d = in_slice;
            default: ;
          endcase
        end
        default: begin
          // UPDATE: RAM data addressed since EXEC is valid now
          phase_d = PH_FETCH;
          pc_d    = pc_inc;
          case (op)
            OP_LDA: if (sel[0]) a_d = RAM_RDATA;
            OP_LDB: if (sel[0]) b_d = RAM_RDATA;
            OP_JMP: if (jmp_taken) pc_d = pc_tgt;
            OP_CALL: begin
              if (int'(sp_q) == STACK_D) begin
                err_d    = 1'b1;
                halted_d = 1'b1;
                pc_d     = pc_q;
                phase_d  = phase_q;
              end else begin
                for (int i = 0; i < STACK_D; i++) begin
                  if (int'(sp_q) == i) stack_d[i] = pc_inc;
                end
                sp_d = sp_q + SP_W'(1);
                pc_d = pc_tgt;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                err_d    = 1'b1;
                halted_d = 1'b1;
                pc_d     = pc_q;
                phase_d  = phase_q;
              end else begin
                sp_d = sp_q - SP_W'(1);
                pc_d = pop_pc;
              end
            end
            OP_HALT: begin
              halted_d = 1'b1;
              pc_d     = pc_q;
              phase_d  = phase_q;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ram_addr_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= 1'b0;
      s_q        <= 1'b0;
      c_q        <= 1'b0;
      sp_q       <= '0;
      for (int i = 0; i < STACK_D; i++) stack_q[i] <= '0;
      port_out_q <= '0;
      port_oe_q  <= '0;
      phase_q    <= PH_FETCH;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ram_addr_q <= ram_addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      z_q        <= z_d;
      s_q        <= s_d;
      c_q        <= c_d;
      sp_q       <= sp_d;
      stack_q    <= stack_d;
      port_out_q <= port_out_d;
      port_oe_q  <= port_oe_d;
      phase_q    <= phase_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign ROM_ADDR  = pc_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = a_q;
  // Write strobe only in STA EXEC; RST kills it in the same cycle so an aborted STA never writes
  assign RAM_WE    = (phase_q == PH_EXEC) && (op == OP_STA) && !halted_q && !RST;
  assign PORT_OUT  = port_out_q;
  assign PORT_OE   = port_oe_q;
  assign PHASE     = phase_q;
  assign HALTED    = halted_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_riscy_core_p.sv
// Self-checking bench for riscy_core_p with default parameters.
// Latency: expectations are keyed to the cycle count after reset release.
// Backpressure: none; ROM is combinational, RAM is a synchronous-read model.
module tb_riscy_core_p;
  import riscy_pkg::*;

  localparam int K_A     = 0;
  localparam int K_FLG   = 1;
  localparam int K_ROM   = 2;
  localparam int K_POUT  = 3;
  localparam int K_POE   = 4;
  localparam int K_ERR   = 5;
  localparam int K_HALT  = 6;
  localparam int K_PHASE = 7;
  localparam int K_WE    = 8;
  localparam int K_RADDR = 9;
  localparam int K_WDATA = 10;
  localparam int K_MEM3  = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rom_addr;
  logic [23:0] rom_data;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic [15:0] port_oe;
  logic [1:0]  phase;
  logic        halted;
  logic        err;

  logic [23:0] rom [32];
  logic [7:0]  mem [32];
  logic        mem_clr;

  int checks;
  int failures;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];

  riscy_core_p dut (
    .CLK       (clk),
    .RST       (rst),
    .ROM_ADDR  (rom_addr),
    .ROM_DATA  (rom_data),
    .RAM_ADDR  (ram_addr),
    .RAM_WDATA (ram_wdata),
    .RAM_WE    (ram_we),
    .RAM_RDATA (ram_rdata),
    .PORT_IN   (port_in),
    .PORT_OUT  (port_out),
    .PORT_OE   (port_oe),
    .PHASE     (phase),
    .HALTED    (halted),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [23:0] ins(input logic [3:0] op, input logic [3:0] sel,
                                      input logic [7:0] adr, input logic [7:0] imm);
    return {op, sel, adr, imm};
  endfunction

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_A:     return 32'(dut.a_q);
      K_FLG:   return 32'({dut.z_q, dut.s_q, dut.c_q});
      K_ROM:   return 32'(rom_addr);
      K_POUT:  return 32'(port_out);
      K_POE:   return 32'(port_oe);
      K_ERR:   return 32'(err);
      K_HALT:  return 32'(halted);
      K_PHASE: return 32'(phase);
      K_WE:    return 32'(ram_we);
      K_RADDR: return 32'(ram_addr);
      K_WDATA: return 32'(ram_wdata);
      K_MEM3:  return 32'(mem[3]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int cyc, input int kind, input logic [31:0] exp, input string tag);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mem_clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_clr = 1'b0;
  endtask

  // Step ncyc clocks after reset release, popping expectations due each cycle
  task automatic run(input int ncyc, input int rst_at);
    exp_t e;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
      end
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        check_val(e.tag, obs(e.kind), e.exp);
      end
    end
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst      = 1'b1;
    mem_clr  = 1'b1;
    port_in  = '0;
    checks   = 0;
    failures = 0;

    // Reset state, then LDA 7F / LDB 01 / ADD / HALT
    rom_clear();
    rom[0] = ins(OP_LDA, 4'd0, 8'd0, 8'h7F);
    rom[1] = ins(OP_LDB, 4'd0, 8'd0, 8'h01);
    rom[2] = ins(OP_ADD, 4'd0, 8'd0, 8'h00);
    rom[3] = ins(OP_HALT, 4'd0, 8'd0, 8'h00);
    push(0, K_ROM, 0, "rst_pc");
    push(0, K_PHASE, 0, "rst_phase");
    push(0, K_A, 0, "rst_a");
    push(0, K_POUT, 0, "rst_pout");
    push(0, K_POE, 0, "rst_poe");
    push(0, K_HALT, 0, "rst_halt");
    push(0, K_ERR, 0, "rst_err");
    push(0, K_WE, 0, "rst_we");
    push(12, K_A, 32'h80, "add_a");
    push(12, K_FLG, 32'b010, "add_flags");
    push(16, K_HALT, 1, "halt_set");
    push(16, K_ROM, 3, "halt_pc");
    push(20, K_ROM, 3, "halt_hold_pc");
    push(20, K_A, 32'h80, "halt_hold_a");
    push(20, K_WE, 0, "halt_we");
    do_reset();
    run(20, -1);

    // SUB borrow, taken JMP on C, inverted-C JMP not taken
    rom_clear();
    rom[0]  = ins(OP_LDA, 4'd0, 8'd0, 8'h03);
    rom[1]  = ins(OP_LDB, 4'd0, 8'd0, 8'h05);
    rom[2]  = ins(OP_SUB, 4'd0, 8'd0, 8'h00);
    rom[3]  = ins(OP_JMP, 4'd2, 8'd20, 8'h00);
    rom[20] = ins(OP_JMP, 4'b1010, 8'd0, 8'h00);
    rom[21] = ins(OP_HALT, 4'd0, 8'd0, 8'h00);
    push(12, K_A, 32'hFE, "sub_a");
    push(12, K_FLG, 32'b011, "sub_flags");
    push(16, K_ROM, 20, "jmpc_taken");
    push(16, K_PHASE, 0, "jmpc_fetch");
    push(20, K_ROM, 21, "jmpnc_not_taken");
    push(24, K_HALT, 1, "sub_halt");
    do_reset();
    run(24, -1);

    // Logic ops, ADD carry, Z/S branches and PC wrap at 31
    rom_clear();
    rom[0]  = ins(OP_LDA, 4'd0, 8'd0, 8'h0F);
    rom[1]  = ins(OP_LDB, 4'd0, 8'd0, 8'hF0);
    rom[2]  = ins(OP_AND, 4'd0, 8'd0, 8'h00);
    rom[3]  = ins(OP_OR, 4'd0, 8'd0, 8'h00);
    rom[4]  = ins(OP_XOR, 4'd0, 8'd0, 8'h00);
    rom[5]  = ins(OP_LDA, 4'd0, 8'd0, 8'hFF);
    rom[6]  = ins(OP_ADD, 4'd0, 8'd0, 8'h00);
    rom[7]  = ins(OP_JMP, 4'd1, 8'd30, 8'h00);
    rom[8]  = ins(OP_JMP, 4'd3, 8'd31, 8'h00);
    push(12, K_A, 32'h00, "and_a");
    push(12, K_FLG, 32'b100, "and_flags");
    push(16, K_A, 32'hF0, "or_a");
    push(16, K_FLG, 32'b010, "or_flags");
    push(20, K_A, 32'h00, "xor_a");
    push(20, K_FLG, 32'b100, "xor_flags");
    push(24, K_FLG, 32'b100, "lda_keeps_flags");
    push(28, K_A, 32'hEF, "addc_a");
    push(28, K_FLG, 32'b011, "addc_flags");
    push(32, K_ROM, 8, "jmpz_not_taken");
    push(36, K_ROM, 31, "jmps_taken");
    push(40, K_ROM, 0, "pc_wrap");
    do_reset();
    run(40, -1);

    // Port direction / output / input, including out-of-range ports
    rom_clear();
    port_in = 16'h5AC3;
    rom[0] = ins(OP_DIR, 4'd1, 8'd0, 8'hF0);
    rom[1] = ins(OP_LDA, 4'd0, 8'd0, 8'hA5);
    rom[2] = ins(OP_OUT, 4'd1, 8'd0, 8'h00);
    rom[3] = ins(OP_OUT, 4'd5, 8'd0, 8'h00);
    rom[4] = ins(OP_LDA, 4'd0, 8'd0, 8'h3C);
    rom[5] = ins(OP_OUT, 4'd0, 8'd0, 8'h00);
    rom[6] = ins(OP_IN, 4'd1, 8'd0, 8'h00);
    rom[7] = ins(OP_IN, 4'd6, 8'd0, 8'h00);
    rom[8] = ins(OP_HALT, 4'd0, 8'd0, 8'h00);
    push(4, K_POE, 32'hF000, "dir_p1");
    push(12, K_POUT, 32'hA500, "out_p1");
    push(16, K_POUT, 32'hA500, "out_p5_ignored");
    push(16, K_POE, 32'hF000, "oe_hold");
    push(24, K_POUT, 32'hA53C, "out_p0");
    push(28, K_A, 32'h5A, "in_p1");
    push(32, K_A, 32'h00, "in_p6_zero");
    push(36, K_HALT, 1, "port_halt");
    do_reset();
    run(36, -1);
    port_in = '0;

    // Five nested CALLs overflow a four-deep stack
    rom_clear();
    rom[0]  = ins(OP_CALL, 4'd0, 8'd4, 8'h00);
    rom[4]  = ins(OP_CALL, 4'd0, 8'd8, 8'h00);
    rom[8]  = ins(OP_CALL, 4'd0, 8'd12, 8'h00);
    rom[12] = ins(OP_CALL, 4'd0, 8'd16, 8'h00);
    rom[16] = ins(OP_CALL, 4'd0, 8'd20, 8'h00);
    push(4, K_ROM, 4, "call1_pc");
    push(16, K_ROM, 16, "call4_pc");
    push(16, K_ERR, 0, "call4_no_err");
    push(20, K_ERR, 1, "call5_err");
    push(20, K_HALT, 1, "call5_halt");
    push(20, K_ROM, 16, "call5_pc_kept");
    push(24, K_ROM, 16, "call5_pc_hold");
    do_reset();
    run(24, -1);

    // Nested CALL/RET returns in LIFO order, then RET on empty stack faults
    rom_clear();
    rom[0]  = ins(OP_CALL, 4'd0, 8'd10, 8'h00);
    rom[10] = ins(OP_CALL, 4'd0, 8'd20, 8'h00);
    rom[20] = ins(OP_RET, 4'd0, 8'd0, 8'h00);
    rom[11] = ins(OP_RET, 4'd0, 8'd0, 8'h00);
    rom[1]  = ins(OP_RET, 4'd0, 8'd0, 8'h00);
    push(4, K_ROM, 10, "call_a");
    push(8, K_ROM, 20, "call_b");
    push(12, K_ROM, 11, "ret_b");
    push(16, K_ROM, 1, "ret_a");
    push(16, K_ERR, 0, "ret_a_no_err");
    push(20, K_ERR, 1, "ret_empty_err");
    push(20, K_HALT, 1, "ret_empty_halt");
    push(20, K_ROM, 1, "ret_empty_pc");
    do_reset();
    run(20, -1);

    // RET straight after reset
    rom_clear();
    rom[0] = ins(OP_RET, 4'd0, 8'd0, 8'h00);
    push(4, K_ERR, 1, "ret_rst_err");
    push(4, K_HALT, 1, "ret_rst_halt");
    push(4, K_ROM, 0, "ret_rst_pc");
    do_reset();
    run(4, -1);

    // STA write strobe timing and RAM load back
    rom_clear();
    rom[0] = ins(OP_LDA, 4'd0, 8'd0, 8'h42);
    rom[1] = ins(OP_STA, 4'd0, 8'd3, 8'h00);
    rom[2] = ins(OP_LDA, 4'd0, 8'd0, 8'h00);
    rom[3] = ins(OP_LDA, 4'd1, 8'd3, 8'h00);
    rom[4] = ins(OP_HALT, 4'd0, 8'd0, 8'h00);
    push(5, K_WE, 0, "sta_fetch_we");
    push(6, K_WE, 1, "sta_exec_we");
    push(6, K_RADDR, 3, "sta_addr");
    push(6, K_WDATA, 32'h42, "sta_wdata");
    push(7, K_WE, 0, "sta_update_we");
    push(8, K_MEM3, 32'h42, "sta_mem");
    push(12, K_A, 32'h00, "lda_imm0");
    push(16, K_A, 32'h42, "lda_ram");
    do_reset();
    run(16, -1);

    // RST during STA EXEC aborts the write and restores reset values
    rom_clear();
    rom[0] = ins(OP_DIR, 4'd0, 8'd0, 8'hFF);
    rom[1] = ins(OP_LDA, 4'd0, 8'd0, 8'h77);
    rom[2] = ins(OP_OUT, 4'd0, 8'd0, 8'h00);
    rom[3] = ins(OP_STA, 4'd0, 8'd3, 8'h00);
    push(12, K_POE, 32'h00FF, "pre_rst_oe");
    push(12, K_POUT, 32'h0077, "pre_rst_out");
    push(14, K_PHASE, 2, "abort_in_exec");
    push(14, K_WE, 0, "abort_we_forced");
    push(15, K_WE, 0, "post_rst_we");
    push(15, K_MEM3, 0, "abort_no_write");
    push(15, K_ROM, 0, "post_rst_pc");
    push(15, K_PHASE, 0, "post_rst_phase");
    push(15, K_POUT, 0, "post_rst_out");
    push(15, K_POE, 0, "post_rst_oe");
    push(15, K_A, 0, "post_rst_a");
    push(15, K_HALT, 0, "post_rst_halt");
    push(15, K_ERR, 0, "post_rst_err");
    do_reset();
    run(15, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscy_core_p.md
RISCY_CORE_P -- requirements
Module: riscy_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/port width (4..16).
REQ-002 SHALL have parameter PC_W, default 5, program address width (<=8).
REQ-003 SHALL have parameter RAM_AW, default 5, RAM address width (<=8).
REQ-004 SHALL have parameter NPORTS, default 2, number of I/O ports (1..8).
REQ-005 SHALL have parameter STACK_D, default 4, call-stack depth.
REQ-006 SHALL use one clock; reset is synchronous and active-high: CLK in 1 clock, rising edge; RST in 1 synchronous active-high reset.
REQ-007 SHALL have ROM_ADDR out PC_W, instruction fetch address.
REQ-008 SHALL have ROM_DATA in 16+DATA_W, instruction word, combinational from ROM_ADDR.
REQ-009 SHALL have RAM_ADDR out RAM_AW, data RAM address.
REQ-010 SHALL have RAM_WDATA out DATA_W, write data.
REQ-011 SHALL have RAM_WE out 1, write strobe (one cycle).
REQ-012 SHALL have RAM_RDATA in DATA_W, read data, valid one cycle after RAM_ADDR.
REQ-013 SHALL have PORT_IN in NPORTS*DATA_W, pin values.
REQ-014 SHALL have PORT_OUT out NPORTS*DATA_W, port data registers.
REQ-015 SHALL have PORT_OE out NPORTS*DATA_W, per-bit direction (1=drive).
REQ-016 SHALL have PHASE out 2, current phase; HALTED out 1; ERR out 1, stack fault.

Function
REQ-017 Instruction fields SHALL be OP=[IW-1:IW-4], SEL=[IW-5:IW-8], ADR=[IW-9:IW-16], IMM=[DATA_W-1:0]; ADR truncated to PC_W/RAM_AW.
REQ-018 Every instruction SHALL take exactly four cycles: FETCH (IR<=ROM_DATA at PC), DECODE (RAM_ADDR<=ADR), EXEC, UPDATE (PC/SP change); PHASE encodes 0..3.
REQ-019 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDA, 7 LDB, 8 STA, 9 OUT, 10 DIR, 11 IN, 12 JMP, 13 CALL, 14 RET, 15 HALT.
REQ-020 ALU ops 1-5 SHALL write A<=A op B modulo 2^DATA_W and update flags Z (result zero), S (result MSB), C (ADD carry-out; SUB borrow when A<B; 0 for logic ops).
REQ-021 LDA/LDB SHALL load IMM when SEL[0]=0, else RAM_RDATA at ADR; flags unchanged.
REQ-022 STA SHALL drive RAM_WDATA=A and RAM_WE=1 for the EXEC cycle only.
REQ-023 OUT/DIR/IN SHALL address port SEL[2:0]: OUT data<=A, DIR direction<=IMM, IN A<=PORT_IN slice sampled in EXEC; SEL>=NPORTS: OUT/DIR no effect, IN loads 0.
REQ-024 JMP SHALL load PC<=ADR when cond SEL[1:0] (0 always, 1 Z, 2 C, 3 S) XOR SEL[3] is true, else PC+1.
REQ-025 CALL SHALL push PC+1 and jump to ADR; RET SHALL pop into PC.
REQ-026 CALL with STACK_D entries held, or RET with stack empty, SHALL set ERR=1 and HALTED=1 with no PC/SP change.
REQ-027 HALT SHALL set HALTED=1; halted core SHALL hold all state, RAM_WE=0, until RST.
REQ-028 PC+1 SHALL wrap from 2^PC_W-1 to 0; SP SHALL never wrap.
REQ-029 Undriven timing rule: RAM_WE SHALL be 0 in all phases except STA EXEC.

Reset
REQ-030 RST sampled high SHALL, on that edge, set PC=0, A=B=0, Z=C=S=0, SP=0, IR=0, PHASE=FETCH, PORT_OUT=0, PORT_OE=0 (all inputs), HALTED=0, ERR=0, RAM_WE=0.
REQ-031 RST asserted mid-instruction SHALL abort it; a STA in EXEC the same cycle SHALL not write (RAM_WE forced 0 combinationally by RST).

Structure
REQ-032 Package riscy_pkg SHALL hold the opcode enum, phase enum, condition codes and instruction field positions.
REQ-033 Arithmetic/flags SHALL live in one sub-module riscy_alu_p (combinational, DATA_W parameter).

Verification
REQ-034 LDA #8'h7F, LDB #8'h01, ADD -> A=8'h80, S=1, C=0, Z=0 after 12 cycles.
REQ-035 LDA #3, LDB #5, SUB -> A=8'hFE, C=1; then JMP cond C to 5'd20 -> ROM_ADDR=20 at next FETCH.
REQ-036 DIR port1 IMM=8'hF0, LDA #8'hA5, OUT port1 -> PORT_OE[15:8]=8'hF0, PORT_OUT[15:8]=8'hA5; OUT port 5 (NPORTS=2) -> no change.
REQ-037 Five nested CALLs (STACK_D=4) -> fifth sets ERR=1, HALTED=1, PC stays at fifth CALL address; RET on empty stack after reset -> ERR=1.
REQ-038 STA to ADR 3, RST asserted during its EXEC -> RAM_WE never 1, all outputs at reset values next cycle.
REQ-039 PC at 31 executing NOP (PC_W=5) -> next ROM_ADDR=0.
